// File: rtl/axi_lite_reg_slave.sv
// rtl/axi_lite_reg_slave.sv - AXI4-Lite slave with CTRL/DOUT RW and STATUS/DIN RO registers
module axi_lite_reg_slave #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    RESP_WIDTH = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [DATA_WIDTH-1:0] CTRL_RST   = '0
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   ctrl_o,
  output logic [DATA_WIDTH-1:0]   dout_o,
  input  logic [DATA_WIDTH-17:0]  status_i,
  input  logic [DATA_WIDTH-1:0]   din_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);
  localparam logic [RESP_WIDTH-1:0] RESP_DECERR = RESP_WIDTH'(3);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                  aw_hs, w_hs, ar_hs, wr_fire;
  logic [ADDR_WIDTH-1:0] aw_addr_q, wr_addr, wr_off, rd_off;
  logic [DATA_WIDTH-1:0] w_data_q, wr_data, rd_data;
  logic [STRB_WIDTH-1:0] w_strb_q, wr_strb;
  logic [RESP_WIDTH-1:0] wr_resp, rd_resp;
  logic [15:0]           wr_cnt;
  logic                  unused_strb_msb;

  assign unused_strb_msb = s_axi_wstrb[STRB_WIDTH];

  function automatic logic [RESP_WIDTH-1:0] decode_resp(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic is_write);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    if (addr[1:0] != 2'b00)            return RESP_SLVERR;
    else if (off > ADDR_WIDTH'(12))    return RESP_DECERR;
    else if (is_write && off[3])       return RESP_SLVERR;
    else                               return RESP_OKAY;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] cur,
                                                        input logic [DATA_WIDTH-1:0] upd,
                                                        input logic [STRB_WIDTH-1:0] strb);
    logic [DATA_WIDTH-1:0] res;
    res = cur;
    for (int i = 0; i < STRB_WIDTH; i++)
      if (strb[i]) res[8*i +: 8] = upd[8*i +: 8];
    return res;
  endfunction

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next  = w_state;
    wr_fire = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_next  = W_RESP;
          wr_fire = 1'b1;
        end else if (aw_hs) begin
          w_next = W_ADDR;
        end else if (w_hs) begin
          w_next = W_DATA;
        end
      end
      W_ADDR: if (w_hs) begin
        w_next  = W_RESP;
        wr_fire = 1'b1;
      end
      W_DATA: if (aw_hs) begin
        w_next  = W_RESP;
        wr_fire = 1'b1;
      end
      W_RESP: if (s_axi_bvalid && s_axi_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // The half of the write that arrived first comes from the holding registers.
  always_comb begin
    wr_addr = (w_state == W_ADDR) ? aw_addr_q : s_axi_awaddr;
    wr_data = (w_state == W_DATA) ? w_data_q  : s_axi_wdata;
    wr_strb = (w_state == W_DATA) ? w_strb_q  : s_axi_wstrb[STRB_WIDTH-1:0];
    wr_off  = wr_addr - BASE_ADDR;
    wr_resp = decode_resp(wr_addr, 1'b1);
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (s_axi_rvalid && s_axi_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_off  = s_axi_araddr - BASE_ADDR;
    rd_resp = decode_resp(s_axi_araddr, 1'b0);
    rd_data = '0;
    if (rd_resp == RESP_OKAY) begin
      if (rd_off == ADDR_WIDTH'(0))      rd_data = ctrl_o;
      else if (rd_off == ADDR_WIDTH'(4)) rd_data = dout_o;
      else if (rd_off == ADDR_WIDTH'(8)) rd_data = {wr_cnt, status_i};
      else                               rd_data = din_i;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_arready <= 1'b0;
    end else begin
      s_axi_awready <= (w_next == W_IDLE) || (w_next == W_DATA);
      s_axi_wready  <= (w_next == W_IDLE) || (w_next == W_ADDR);
      s_axi_bvalid  <= (w_next == W_RESP);
      s_axi_arready <= (r_next == R_IDLE);
    end
  end

  assign s_axi_rvalid = (r_state == R_DATA);

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      s_axi_bresp <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= '0;
      ctrl_o      <= CTRL_RST;
      dout_o      <= CTRL_RST;
      wr_cnt      <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= s_axi_awaddr;
      if (w_hs) begin
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb[STRB_WIDTH-1:0];
      end
      if (wr_fire) begin
        s_axi_bresp <= wr_resp;
        if (wr_resp == RESP_OKAY) begin
          wr_cnt <= wr_cnt + 16'd1;
          if (wr_off == ADDR_WIDTH'(0)) ctrl_o <= merge_bytes(ctrl_o, wr_data, wr_strb);
          else                          dout_o <= merge_bytes(dout_o, wr_data, wr_strb);
        end
      end
      // Reads sample registers before any same-edge write lands.
      if (ar_hs) begin
        s_axi_rdata <= rd_data;
        s_axi_rresp <= rd_resp;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb/tb_axi_lite_reg_slave.sv - randomized self-checking bench for axi_lite_reg_slave
module tb_axi_lite_reg_slave;
  logic        clk = 1'b0;
  logic        areset;
  logic [7:0]  s_axi_awaddr, s_axi_araddr;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [4:0]  s_axi_wstrb;
  logic [2:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  logic [31:0] ctrl_o, dout_o, din_i;
  logic [15:0] status_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  logic [31:0] ref_ctrl, ref_dout;
  logic [15:0] ref_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  axi_lite_reg_slave dut (
    .s_axi_aclk(clk), .s_axi_areset(areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .ctrl_o(ctrl_o), .dout_o(dout_o),
    .status_i(status_i), .din_i(din_i)
  );

  function automatic logic [2:0] exp_resp(input logic [7:0] addr, input bit is_write);
    if (addr % 4 != 0) return 3'd2;
    if (addr > 8'h0C) return 3'd3;
    if (is_write && (addr == 8'h08 || addr == 8'h0C)) return 3'd2;
    return 3'd0;
  endfunction

  function automatic logic [31:0] exp_read(input logic [7:0] addr);
    if (exp_resp(addr, 0) != 3'd0) return 32'h0;
    case (addr)
      8'h00:   return ref_ctrl;
      8'h04:   return ref_dout;
      8'h08:   return {ref_cnt, status_i};
      default: return din_i;
    endcase
  endfunction

  task automatic model_reset;
    ref_ctrl = 32'h0; ref_dout = 32'h0; ref_cnt = 16'h0;
  endtask

  task automatic model_write(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb);
    logic [31:0] mask;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
    if (exp_resp(addr, 1) == 3'd0) begin
      if (addr == 8'h00) ref_ctrl = (ref_ctrl & ~mask) | (data & mask);
      else               ref_dout = (ref_dout & ~mask) | (data & mask);
      ref_cnt = (ref_cnt == 16'hFFFF) ? 16'h0 : ref_cnt + 16'd1;
    end
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb,
                           input int aw_dly, input int w_dly, input int b_hold,
                           output logic [2:0] resp, output bit b_prompt, output bit early_b,
                           output bit hold_ok, output bit timeout);
    bit aw_done, w_done;
    int cyc;
    logic [2:0] r0;
    aw_done = 0; w_done = 0; cyc = 0;
    resp = 3'b111; b_prompt = 0; early_b = 0; hold_ok = 1; timeout = 0;
    while (!(aw_done && w_done)) begin
      if (cyc >= 200) begin timeout = 1; break; end
      s_axi_awaddr  = addr;
      s_axi_awvalid = !aw_done && cyc >= aw_dly;
      s_axi_wdata   = data;
      s_axi_wstrb   = strb;
      s_axi_wvalid  = !w_done && cyc >= w_dly;
      if (s_axi_bvalid) early_b = 1;
      if (s_axi_awvalid && s_axi_awready) aw_done = 1;
      if (s_axi_wvalid && s_axi_wready) w_done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    if (timeout) return;
    model_write(addr, data, strb);
    b_prompt = s_axi_bvalid;
    cyc = 0;
    while (!s_axi_bvalid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    if (!s_axi_bvalid) begin timeout = 1; return; end
    r0 = s_axi_bresp;
    for (int i = 0; i < b_hold; i++) begin
      @(posedge clk); #1;
      if (!s_axi_bvalid || s_axi_bresp !== r0 || s_axi_awready || s_axi_wready) hold_ok = 0;
    end
    s_axi_bready = 1;
    resp = s_axi_bresp;
    @(posedge clk); #1;
    s_axi_bready = 0;
    if (s_axi_bvalid) hold_ok = 0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [2:0] resp,
                          output bit r_prompt, output bit timeout);
    int cyc;
    bit done;
    cyc = 0; done = 0; timeout = 0; r_prompt = 0; data = 32'hX; resp = 3'b111;
    s_axi_araddr = addr;
    s_axi_arvalid = 1;
    while (!done) begin
      if (cyc >= 50) begin timeout = 1; break; end
      if (s_axi_arready) done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    s_axi_arvalid = 0;
    if (timeout) return;
    r_prompt = s_axi_rvalid;
    cyc = 0;
    while (!s_axi_rvalid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    if (!s_axi_rvalid) begin timeout = 1; return; end
    data = s_axi_rdata;
    resp = s_axi_rresp;
    s_axi_rready = 1;
    @(posedge clk); #1;
    s_axi_rready = 0;
  endtask

  task automatic test_reset;
    logic [31:0] rd; logic [2:0] rr; bit rp, to;
    areset = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: got %b expected 00000",
               {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid});
    end
    n_checks++;
    if ({ctrl_o, dout_o, s_axi_rdata, s_axi_bresp, s_axi_rresp} !== {ref_ctrl, ref_dout, 32'h0, 6'h0}) begin
      n_fail++;
      $display("FAIL reset_data: got ctrl=%h dout=%h rdata=%h bresp=%0d rresp=%0d expected all zero",
               ctrl_o, dout_o, s_axi_rdata, s_axi_bresp, s_axi_rresp);
    end
    areset = 0;
    @(posedge clk); #1;
    n_checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      n_fail++;
      $display("FAIL idle_ready: got %b expected 111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
    status_i = 16'h1234;
    axi_read(8'h00, rd, rr, rp, to);
    n_checks++;
    if (to || rd !== exp_read(8'h00) || rr !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_read_ctrl: got rdata=%h rresp=%0d timeout=%0d expected rdata=%h rresp=0",
               rd, rr, to, exp_read(8'h00));
    end
    axi_read(8'h08, rd, rr, rp, to);
    n_checks++;
    if (to || rd !== 32'h00001234 || rr !== 3'd0 || !rp) begin
      n_fail++;
      $display("FAIL reset_read_status: got rdata=%h rresp=%0d rvalid_next=%0d expected 00001234/0/1",
               rd, rr, rp);
    end
  endtask

  task automatic test_same_cycle;
    logic [2:0] resp, rr; bit bp, eb, ho, to, rp, rto; logic [31:0] rd;
    axi_write(8'h04, 32'hDEADBEEF, 5'h0F, 0, 0, 0, resp, bp, eb, ho, to);
    n_checks++;
    if (to || resp !== 3'd0 || !bp) begin
      n_fail++;
      $display("FAIL same_cycle_bresp: got resp=%0d bvalid_next=%0d timeout=%0d expected 0/1/0", resp, bp, to);
    end
    n_checks++;
    if (dout_o !== ref_dout || ref_dout !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL same_cycle_dout: got %h expected %h", dout_o, ref_dout);
    end
    axi_read(8'h08, rd, rr, rp, rto);
    n_checks++;
    if (rto || rd[31:16] !== 16'd1) begin
      n_fail++;
      $display("FAIL same_cycle_wr_cnt: got %h expected 0001", rd[31:16]);
    end
  endtask

  task automatic test_w_first;
    logic [2:0] resp; bit bp, eb, ho, to;
    axi_write(8'h00, 32'h11223344, 5'h0F, 0, 0, 0, resp, bp, eb, ho, to);
    axi_write(8'h00, 32'h000000AA, 5'h01, 3, 0, 0, resp, bp, eb, ho, to);
    n_checks++;
    if (to || eb || !bp || resp !== 3'd0) begin
      n_fail++;
      $display("FAIL w_first_bvalid: got early=%0d prompt=%0d resp=%0d timeout=%0d expected 0/1/0/0",
               eb, bp, resp, to);
    end
    n_checks++;
    if (ctrl_o !== ref_ctrl || ref_ctrl !== 32'h112233AA) begin
      n_fail++;
      $display("FAIL w_first_ctrl: got %h expected %h", ctrl_o, ref_ctrl);
    end
    axi_write(8'h04, 32'h55667788, 5'h0A, 0, 2, 0, resp, bp, eb, ho, to);
    n_checks++;
    if (to || eb || dout_o !== ref_dout) begin
      n_fail++;
      $display("FAIL aw_first_dout: got %h expected %h", dout_o, ref_dout);
    end
  endtask

  task automatic test_errors;
    logic [7:0] waddr[3] = '{8'h0C, 8'h10, 8'h02};
    logic [7:0] raddr[3] = '{8'h02, 8'h14, 8'h0D};
    logic [2:0] resp, rr; bit bp, eb, ho, to, rp; logic [31:0] rd;
    for (int i = 0; i < 3; i++) begin
      axi_write(waddr[i], 32'hFFFFFFFF, 5'h1F, 0, 0, 0, resp, bp, eb, ho, to);
      n_checks++;
      if (to || resp !== exp_resp(waddr[i], 1) || ctrl_o !== ref_ctrl || dout_o !== ref_dout) begin
        n_fail++;
        $display("FAIL err_write_%h: got resp=%0d ctrl=%h dout=%h expected resp=%0d ctrl=%h dout=%h",
                 waddr[i], resp, ctrl_o, dout_o, exp_resp(waddr[i], 1), ref_ctrl, ref_dout);
      end
      axi_read(raddr[i], rd, rr, rp, to);
      n_checks++;
      if (to || rr !== exp_resp(raddr[i], 0) || rd !== 32'h0) begin
        n_fail++;
        $display("FAIL err_read_%h: got rresp=%0d rdata=%h expected rresp=%0d rdata=0",
                 raddr[i], rr, rd, exp_resp(raddr[i], 0));
      end
    end
    axi_read(8'h08, rd, rr, rp, to);
    n_checks++;
    if (to || rd !== exp_read(8'h08)) begin
      n_fail++;
      $display("FAIL err_wr_cnt: got %h expected %h", rd, exp_read(8'h08));
    end
  endtask

  task automatic test_bresp_hold;
    logic [2:0] resp, rr; bit bp, eb, ho, to, rp; logic [31:0] rd;
    axi_write(8'h10, 32'h0, 5'h0F, 0, 0, 5, resp, bp, eb, ho, to);
    n_checks++;
    if (to || !ho || resp !== 3'd3) begin
      n_fail++;
      $display("FAIL bresp_hold: got stable=%0d resp=%0d timeout=%0d expected 1/3/0", ho, resp, to);
    end
    @(negedge clk);
    force dut.wr_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.wr_cnt;
    @(posedge clk); #1;
    ref_cnt = 16'hFFFF;
    axi_write(8'h04, 32'h0, 5'h00, 1, 0, 0, resp, bp, eb, ho, to);
    n_checks++;
    if (to || resp !== 3'd0 || dout_o !== ref_dout) begin
      n_fail++;
      $display("FAIL zero_strb_write: got resp=%0d dout=%h expected 0/%h", resp, dout_o, ref_dout);
    end
    axi_read(8'h08, rd, rr, rp, to);
    n_checks++;
    if (to || rd !== exp_read(8'h08) || ref_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL wr_cnt_wrap: got %h expected %h", rd, exp_read(8'h08));
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] resp, rr; bit bp, eb, ho, to, rp, rto; logic [31:0] rd, exp_rd; int t0;
    logic [31:0] wd;
    exp_rd = exp_read(8'h00);
    fork
      axi_write(8'h00, 32'hA5A5A5A5, 5'h0F, 0, 0, 0, resp, bp, eb, ho, to);
      axi_read(8'h00, rd, rr, rp, rto);
    join
    n_checks++;
    if (to || rto || rd !== exp_rd || ctrl_o !== ref_ctrl) begin
      n_fail++;
      $display("FAIL same_edge_rw: got rdata=%h ctrl=%h expected rdata=%h ctrl=%h", rd, ctrl_o, exp_rd, ref_ctrl);
    end
    t0 = cyc_cnt;
    for (int i = 0; i < 4; i++) begin
      wd = $urandom;
      axi_write(8'h04, wd, 5'h0F, 0, 0, 0, resp, bp, eb, ho, to);
    end
    n_checks++;
    if (cyc_cnt - t0 !== 8 || dout_o !== ref_dout) begin
      n_fail++;
      $display("FAIL back_to_back: got cycles=%0d dout=%h expected cycles=8 dout=%h", cyc_cnt - t0, dout_o, ref_dout);
    end
  endtask

  task automatic test_random;
    logic [7:0] pool[8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h02, 8'h07, 8'h00};
    logic [7:0] addr; logic [31:0] data, rd, exp_rd; logic [4:0] strb;
    logic [2:0] resp, rr; bit bp, eb, ho, to, rp;
    for (int n = 0; n < 40; n++) begin
      addr = (n % 7 == 6) ? 8'($urandom) : pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 5'($urandom);
        axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                  resp, bp, eb, ho, to);
        n_checks++;
        if (to || eb || !ho || resp !== exp_resp(addr, 1) || ctrl_o !== ref_ctrl || dout_o !== ref_dout) begin
          n_fail++;
          $display("FAIL rand_write_%0d: addr=%h got resp=%0d ctrl=%h dout=%h expected resp=%0d ctrl=%h dout=%h",
                   n, addr, resp, ctrl_o, dout_o, exp_resp(addr, 1), ref_ctrl, ref_dout);
        end
      end else begin
        status_i = 16'($urandom);
        din_i    = $urandom;
        exp_rd   = exp_read(addr);
        axi_read(addr, rd, rr, rp, to);
        n_checks++;
        if (to || !rp || rr !== exp_resp(addr, 0) || rd !== exp_rd) begin
          n_fail++;
          $display("FAIL rand_read_%0d: addr=%h got rresp=%0d rdata=%h expected rresp=%0d rdata=%h",
                   n, addr, rr, rd, exp_resp(addr, 0), exp_rd);
        end
      end
    end
  endtask

  task automatic test_reset_midflight;
    bit b_seen;
    s_axi_araddr = 8'h00; s_axi_arvalid = 1;
    s_axi_awaddr = 8'h04; s_axi_awvalid = 1;
    @(posedge clk); #1;
    s_axi_arvalid = 0; s_axi_awvalid = 0;
    n_checks++;
    if (!s_axi_rvalid || s_axi_awready || !s_axi_wready) begin
      n_fail++;
      $display("FAIL midflight_setup: got rvalid=%0d awready=%0d wready=%0d expected 1/0/1",
               s_axi_rvalid, s_axi_awready, s_axi_wready);
    end
    areset = 1;
    @(posedge clk); #1;
    model_reset();
    n_checks++;
    if (s_axi_rvalid || s_axi_bvalid) begin
      n_fail++;
      $display("FAIL midflight_reset: got rvalid=%0d bvalid=%0d expected 0/0", s_axi_rvalid, s_axi_bvalid);
    end
    areset = 0;
    @(posedge clk); #1;
    s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 5'h0F; s_axi_wvalid = 1;
    @(posedge clk); #1;
    s_axi_wvalid = 0;
    b_seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (s_axi_bvalid) b_seen = 1;
    end
    n_checks++;
    if (b_seen || dout_o !== ref_dout || ctrl_o !== ref_ctrl) begin
      n_fail++;
      $display("FAIL midflight_w_alone: got bvalid_seen=%0d dout=%h ctrl=%h expected 0/%h/%h",
               b_seen, dout_o, ctrl_o, ref_dout, ref_ctrl);
    end
  endtask

  initial begin
    areset = 1;
    s_axi_awaddr = 0; s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0;
    s_axi_bready = 0; s_axi_araddr = 0; s_axi_arvalid = 0; s_axi_rready = 0;
    status_i = 0; din_i = 0;
    model_reset();
    test_reset();
    test_same_cycle();
    test_w_first();
    test_errors();
    test_bresp_hold();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
